// File: rtl/out_channel_checker_if.sv
// Out channel between the instruction engine (master) and the checker (slave).
// One word moves on every cycle where out_valid and out_ready are both high.
interface out_channel_checker_if #(
    parameter int MemoryElementWidth = 12
) ();
    logic                          out_valid;
    logic [MemoryElementWidth-1:0] out_data;
    logic                          out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/out_channel_checker.sv
// Captures the engine's out words and compares them in order against a preloaded
// expected list, then reports finished/success/timeout for the FPGA test harness.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 8,
    parameter int MaxSteps           = 1000,
    localparam int IW                = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_valid,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          start,
    input  logic                          clear,
    out_channel_checker_if.slave          out_ch,
    input  logic [IW-1:0]                 rd_addr,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [IW-1:0]                 received,
    output logic                          finished,
    output logic                          success,
    output logic                          timeout,
    output logic [IW-1:0]                 mismatch_index
);
    localparam int AW = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int CW = $clog2(MaxSteps + 1);
    localparam logic [IW-1:0] NOUT_C = IW'(NOut);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(MaxSteps - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 wptr_q, wptr_d;
    logic [IW-1:0]                 rptr_q, rptr_d;
    logic [IW-1:0]                 nexp_q, nexp_d;
    logic [IW-1:0]                 received_q, received_d;
    logic [IW-1:0]                 mm_q, mm_d;
    logic [CW-1:0]                 cycles_q, cycles_d;
    logic                          timeout_q, timeout_d;
    logic                          overrun_q, overrun_d;
    logic                          extra_q, extra_d;
    logic                          exp_we, cap_we, accept, out_ready;

    logic [MemoryElementWidth-1:0] exp_mem [NOut];
    logic [MemoryElementWidth-1:0] cap_mem [NOut];

    assign out_ready        = (state_q != IDLE);
    assign out_ch.out_ready = out_ready;
    assign accept           = out_ch.out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            nexp_q     <= '0;
            received_q <= '0;
            mm_q       <= NOUT_C;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            extra_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            nexp_q     <= nexp_d;
            received_q <= received_d;
            mm_q       <= mm_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            extra_q    <= extra_d;
        end
    end

    // Memories are deliberately left out of reset so a harness can read captures back.
    always_ff @(posedge clock) begin
        if (exp_we) exp_mem[wptr_q[AW-1:0]] <= exp_data;
        if (cap_we) cap_mem[rptr_q[AW-1:0]] <= out_ch.out_data;
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        nexp_d     = nexp_q;
        received_d = received_q;
        mm_d       = mm_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        extra_d    = extra_q;
        exp_we     = 1'b0;
        cap_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (exp_valid) begin
                    if (wptr_q < NOUT_C) begin
                        exp_we = 1'b1;
                        wptr_d = wptr_q + IW'(1);
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                // A write in the same cycle as start is already folded into wptr_d.
                if (start) begin
                    nexp_d     = wptr_d;
                    rptr_d     = '0;
                    cycles_d   = '0;
                    received_d = '0;
                    state_d    = (wptr_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    cap_we = 1'b1;
                    if (out_ch.out_data != exp_mem[rptr_q[AW-1:0]] && mm_q == NOUT_C)
                        mm_d = rptr_q;
                    rptr_d = rptr_q + IW'(1);
                    if (received_q != NOUT_C) received_d = received_q + IW'(1);
                end
                if (accept && rptr_q == nexp_q - IW'(1)) begin
                    state_d = DONE;
                end else if (cycles_q == LAST_CYCLE) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    cycles_d = cycles_q + CW'(1);
                end
            end
            DONE: begin
                if (accept) extra_d = 1'b1;
                if (clear) begin
                    state_d   = IDLE;
                    wptr_d    = '0;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                    extra_d   = 1'b0;
                    mm_d      = NOUT_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < received_q) rd_data = cap_mem[rd_addr[AW-1:0]];
    end

    assign received       = received_q;
    assign finished       = (state_q == DONE);
    assign success        = finished && !timeout_q && !overrun_q && !extra_q && (mm_q == NOUT_C);
    assign timeout        = timeout_q;
    assign mismatch_index = mm_q;
endmodule

// File: tb/tb_out_channel_checker.sv
// Scenario bench for out_channel_checker: drives the out channel and compares
// against a queue-based model of the expected/captured word lists.
module tb_out_channel_checker;
    localparam int MEW   = 12;
    localparam int NOUT  = 8;
    localparam int STEPS = 1000;
    localparam int IW    = $clog2(NOUT + 1);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           exp_valid = 1'b0;
    logic [MEW-1:0] exp_data = '0;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic [IW-1:0]  rd_addr = '0;
    logic [MEW-1:0] rd_data;
    logic [IW-1:0]  received;
    logic           finished, success, timeout;
    logic [IW-1:0]  mismatch_index;

    out_channel_checker_if #(.MemoryElementWidth(MEW)) oc ();

    out_channel_checker #(
        .MemoryElementWidth(MEW),
        .NOut(NOUT),
        .MaxSteps(STEPS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .exp_valid(exp_valid),
        .exp_data(exp_data),
        .start(start),
        .clear(clear),
        .out_ch(oc),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .received(received),
        .finished(finished),
        .success(success),
        .timeout(timeout),
        .mismatch_index(mismatch_index)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: lists and flags, no notion of the RTL's pointers or states.
    logic [MEW-1:0] m_exp[$];
    logic [MEW-1:0] m_cap[NOUT];
    int             m_nexp, m_recv, m_mm;
    bit             m_overrun, m_timeout, m_extra, m_done;

    function automatic bit m_success();
        return m_done && !m_timeout && !m_overrun && !m_extra && (m_mm == NOUT);
    endfunction

    function automatic logic [MEW-1:0] m_rd(input int a);
        return (a < m_recv) ? m_cap[a] : '0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_exp.delete();
        m_nexp = 0; m_recv = 0; m_mm = NOUT;
        m_overrun = 0; m_timeout = 0; m_extra = 0; m_done = 0;
    endtask

    task automatic model_load(input logic [MEW-1:0] w);
        if (m_exp.size() < NOUT) m_exp.push_back(w);
        else m_overrun = 1;
    endtask

    task automatic model_start();
        m_nexp = m_exp.size();
        m_recv = 0;
        m_done = (m_nexp == 0);
    endtask

    task automatic load_word(input logic [MEW-1:0] w);
        exp_valid = 1'b1; exp_data = w;
        tick();
        exp_valid = 1'b0;
        model_load(w);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_exp.delete();
        m_overrun = 0; m_timeout = 0; m_extra = 0; m_done = 0; m_mm = NOUT;
    endtask

    task automatic send(input logic [MEW-1:0] w, input int gap);
        repeat (gap) tick();
        oc.out_valid = 1'b1; oc.out_data = w;
        tick();
        oc.out_valid = 1'b0;
        if (m_done) begin
            m_extra = 1;
        end else begin
            m_cap[m_recv] = w;
            if (w !== m_exp[m_recv] && m_mm == NOUT) m_mm = m_recv;
            m_recv++;
            if (m_recv == m_nexp) m_done = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({finished, success, timeout, oc.out_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got f/s/t/rdy=%b expected 0000", {finished, success, timeout, oc.out_ready});
        end
        vectors++;
        if (received !== 4'd0 || mismatch_index !== 4'd8) begin
            miscompares++;
            $display("FAIL reset_counts got recv=%0d mm=%0d expected 0/8", received, mismatch_index);
        end
        #2 reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        load_word(12'd2);
        do_start();
        repeat (3) tick();
        vectors++;
        if (finished !== 1'b0 || oc.out_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_wait got fin=%b rdy=%b expected 0/1", finished, oc.out_ready);
        end
        send(12'd2, 0);
        vectors++;
        if (finished !== 1'b1 || success !== 1'b1 || mismatch_index !== 4'd8 || received !== 4'd1) begin
            miscompares++;
            $display("FAIL single_done got fin=%b suc=%b mm=%0d recv=%0d expected 1/1/8/1",
                     finished, success, mismatch_index, received);
        end
        do_clear();
        vectors++;
        if (finished !== 1'b0 || success !== 1'b0) begin
            miscompares++;
            $display("FAIL single_clear got fin=%b suc=%b expected 0/0", finished, success);
        end
    endtask

    task automatic test_mismatch();
        load_word(12'd10); load_word(12'd20); load_word(12'd30);
        do_start();
        send(12'd10, 1); send(12'd25, 0); send(12'd30, 2);
        vectors++;
        if (finished !== 1'b1 || success !== 1'b0 || mismatch_index !== 4'd1) begin
            miscompares++;
            $display("FAIL mismatch_flags got fin=%b suc=%b mm=%0d expected 1/0/1", finished, success, mismatch_index);
        end
        rd_addr = 4'd1; #1;
        vectors++;
        if (rd_data !== 12'd25) begin
            miscompares++;
            $display("FAIL mismatch_rd1 got %0d expected 25", rd_data);
        end
        rd_addr = 4'd3; #1;
        vectors++;
        if (rd_data !== 12'd0) begin
            miscompares++;
            $display("FAIL mismatch_rd_oob got %0d expected 0", rd_data);
        end
        do_clear();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(1, NOUT);
            logic [MEW-1:0] w;
            for (int k = 0; k < n; k++) load_word(MEW'($urandom_range(0, 4095)));
            do_start();
            for (int k = 0; k < n; k++) begin
                w = m_exp[k];
                if ($urandom_range(0, 3) == 0) w = w ^ MEW'($urandom_range(1, 4095));
                send(w, $urandom_range(0, 3));
            end
            vectors++;
            if (finished !== 1'b1 || success !== m_success() || mismatch_index !== IW'(m_mm) ||
                received !== IW'(m_recv)) begin
                miscompares++;
                $display("FAIL random_%0d got fin=%b suc=%b mm=%0d recv=%0d expected 1/%b/%0d/%0d",
                         it, finished, success, mismatch_index, received, m_success(), m_mm, m_recv);
            end
            for (int a = 0; a < 16; a++) begin
                rd_addr = IW'(a); #1;
                vectors++;
                if (rd_data !== m_rd(a)) begin
                    miscompares++;
                    $display("FAIL random_rd it=%0d addr=%0d got %0d expected %0d", it, a, rd_data, m_rd(a));
                end
            end
            do_clear();
        end
    endtask

    task automatic test_timeout();
        load_word(12'd5);
        do_start();
        repeat (STEPS - 1) tick();
        vectors++;
        if (finished !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early got fin=%b expected 0", finished);
        end
        tick();
        vectors++;
        if (finished !== 1'b1 || timeout !== 1'b1 || success !== 1'b0 || received !== 4'd0) begin
            miscompares++;
            $display("FAIL timeout_done got fin=%b to=%b suc=%b recv=%0d expected 1/1/0/0",
                     finished, timeout, success, received);
        end
        do_clear();
        // Final handshake lands on the budget edge; completion must win.
        load_word(12'd5);
        do_start();
        repeat (STEPS - 1) tick();
        send(12'd5, 0);
        vectors++;
        if (finished !== 1'b1 || timeout !== 1'b0 || success !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_edge got fin=%b to=%b suc=%b expected 1/0/1", finished, timeout, success);
        end
        do_clear();
    endtask

    task automatic test_extra();
        load_word(12'd1);
        do_start();
        send(12'd1, 0);
        vectors++;
        if (success !== 1'b1) begin
            miscompares++;
            $display("FAIL extra_before got suc=%b expected 1", success);
        end
        send(12'd7, 0);
        vectors++;
        if (success !== m_success() || success !== 1'b0 || received !== 4'd1 || finished !== 1'b1) begin
            miscompares++;
            $display("FAIL extra_after got suc=%b recv=%0d fin=%b expected 0/1/1", success, received, finished);
        end
        do_clear();
    endtask

    task automatic test_overrun();
        for (int k = 0; k < NOUT + 1; k++) load_word(MEW'(100 + k));
        do_start();
        for (int k = 0; k < NOUT; k++) send(MEW'(100 + k), 0);
        vectors++;
        if (finished !== 1'b1 || success !== 1'b0 || mismatch_index !== 4'd8 || received !== 4'd8) begin
            miscompares++;
            $display("FAIL overrun got fin=%b suc=%b mm=%0d recv=%0d expected 1/0/8/8",
                     finished, success, mismatch_index, received);
        end
        do_clear();
        do_start();
        vectors++;
        if (finished !== 1'b1 || success !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_start got fin=%b suc=%b expected 1/1", finished, success);
        end
        do_clear();
        // Load and start in one cycle: the word counts toward the run.
        exp_valid = 1'b1; exp_data = 12'd4; start = 1'b1;
        tick();
        exp_valid = 1'b0; start = 1'b0;
        model_load(12'd4); model_start();
        vectors++;
        if (finished !== 1'b0 || oc.out_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_start got fin=%b rdy=%b expected 0/1", finished, oc.out_ready);
        end
        send(12'd4, 1);
        vectors++;
        if (finished !== 1'b1 || success !== 1'b1) begin
            miscompares++;
            $display("FAIL load_start_done got fin=%b suc=%b expected 1/1", finished, success);
        end
        do_clear();
    endtask

    task automatic test_reset_midrun();
        load_word(12'd3); load_word(12'd3); load_word(12'd3);
        do_start();
        send(12'd3, 0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({finished, success, timeout, oc.out_ready} !== 4'b0000 || received !== 4'd0 ||
            mismatch_index !== 4'd8) begin
            miscompares++;
            $display("FAIL midrun_reset got f/s/t/rdy=%b recv=%0d mm=%0d expected 0000/0/8",
                     {finished, success, timeout, oc.out_ready}, received, mismatch_index);
        end
        #2 reset = 1'b1;
        model_reset();
        tick();
        load_word(12'd3);
        do_start();
        send(12'd3, 0);
        vectors++;
        if (finished !== 1'b1 || success !== 1'b1 || received !== 4'd1) begin
            miscompares++;
            $display("FAIL midrun_reload got fin=%b suc=%b recv=%0d expected 1/1/1", finished, success, received);
        end
    endtask

    initial begin
        oc.out_valid = 1'b0;
        oc.out_data  = '0;
        test_reset();
        test_single();
        test_mismatch();
        test_random();
        test_timeout();
        test_extra();
        test_overrun();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
